// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run/halt/step sequencer for the 16-bit accumulator CPU. Sits between the
// host command port and the core, and drives the core's execute enable and
// PC reset. Provides single-step, one address breakpoint, idle-loop
// termination detection and a saturating executed-cycle counter.
//
// Ports:
//   clk         sole clock, rising edge
//   reset       asynchronous, active-low reset
//   instr_addr  current PC from the core
//   cmd_valid   host command valid
//   cmd_op      0 RUN, 1 HALT, 2 STEP, 3 RESTART
//   cmd_ready   command accepted on clk when cmd_valid & cmd_ready
//   bp_en       breakpoint enable
//   bp_addr     breakpoint address
//   ld_en       idle-loop detect enable
//   cpu_en      core execute enable for this cycle (combinational)
//   cpu_reset   active-high synchronous PC reset
//   state       0 HOLD, 1 HALTED, 2 RUNNING, 3 STEP, 4 DONE
//   bp_hit      sticky flag, set when a breakpoint halts the core
//   cycles      saturating executed-cycle count
module cpu_run_ctrl #(
  parameter int HOLD_CYCLES  = 2,
  parameter bit START_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_addr,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic        ld_en,
  output logic        cpu_en,
  output logic        cpu_reset,
  output logic [2:0]  state,
  output logic        bp_hit,
  output logic [15:0] cycles
);

  localparam logic [1:0] OP_RUN     = 2'd0;
  localparam logic [1:0] OP_HALT    = 2'd1;
  localparam logic [1:0] OP_STEP    = 2'd2;
  localparam logic [1:0] OP_RESTART = 2'd3;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_HALTED  = 3'd1,
    ST_RUNNING = 3'd2,
    ST_STEP    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        resume_q, resume_d;
  logic        bp_hit_q, bp_hit_d;
  logic [15:0] h1_q, h2_q;
  logic [1:0]  hist_cnt_q;
  logic [15:0] cycles_q;
  logic        cmd_acc;
  logic        bp_fire;
  logic        loop_fire;
  logic        enter_hold;

  // Readiness depends on the state register only, never on cmd_valid.
  assign cmd_ready = (state_q == ST_HALTED) || (state_q == ST_RUNNING) ||
                     (state_q == ST_DONE);
  assign cpu_reset = (state_q == ST_HOLD);
  assign cmd_acc   = cmd_valid & cmd_ready;

  // The resume flag masks the breakpoint on the first cycle after RUN so
  // that resuming while parked on bp_addr executes that instruction.
  assign bp_fire   = bp_en && (instr_addr == bp_addr) && !resume_q;

  // h2 is the address executed two cycles ago; seeing it again means the
  // core is spinning in a one- or two-instruction idle loop.
  assign loop_fire = ld_en && (hist_cnt_q == 2'd2) && (instr_addr == h2_q);

  assign enter_hold = (state_d == ST_HOLD);

  assign state  = state_q;
  assign bp_hit = bp_hit_q;
  assign cycles = cycles_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    resume_d   = resume_q;
    bp_hit_d   = bp_hit_q;
    cpu_en     = 1'b0;

    // Any accepted command other than HALT clears the sticky flag; a
    // breakpoint firing in the same cycle sets it again below.
    if (cmd_acc && (cmd_op != OP_HALT)) begin
      bp_hit_d = 1'b0;
    end

    case (state_q)
      ST_HOLD: begin
        resume_d = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = 4'd0;
          state_d    = START_HALTED ? ST_HALTED : ST_RUNNING;
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end

      ST_HALTED: begin
        if (cmd_acc) begin
          case (cmd_op)
            OP_RUN: begin
              state_d  = ST_RUNNING;
              resume_d = 1'b1;
            end
            OP_STEP:    state_d = ST_STEP;
            OP_RESTART: state_d = ST_HOLD;
            default:    state_d = ST_HALTED;
          endcase
        end
      end

      // Priority: RESTART, breakpoint, idle loop, then HALT/STEP. HALT and
      // STEP still let the core execute the current instruction.
      ST_RUNNING: begin
        resume_d = 1'b0;
        if (cmd_acc && (cmd_op == OP_RESTART)) begin
          state_d = ST_HOLD;
        end else if (bp_fire) begin
          bp_hit_d = 1'b1;
          state_d  = ST_HALTED;
        end else if (loop_fire) begin
          state_d = ST_DONE;
        end else begin
          cpu_en = 1'b1;
          if (cmd_acc && ((cmd_op == OP_HALT) || (cmd_op == OP_STEP))) begin
            state_d = ST_HALTED;
          end
        end
      end

      ST_STEP: begin
        cpu_en  = 1'b1;
        state_d = ST_HALTED;
      end

      ST_DONE: begin
        if (cmd_acc && (cmd_op == OP_RESTART)) begin
          state_d = ST_HOLD;
        end
      end

      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= 4'd0;
      resume_q   <= 1'b0;
      bp_hit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      resume_q   <= resume_d;
      bp_hit_q   <= enter_hold ? 1'b0 : bp_hit_d;
    end
  end

  // Loop history and the cycle counter only move on executed cycles and are
  // wiped whenever the sequencer (re)enters HOLD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h1_q       <= 16'd0;
      h2_q       <= 16'd0;
      hist_cnt_q <= 2'd0;
      cycles_q   <= 16'd0;
    end else if (enter_hold) begin
      hist_cnt_q <= 2'd0;
      cycles_q   <= 16'd0;
    end else if (cpu_en) begin
      h1_q <= instr_addr;
      h2_q <= h1_q;
      if (hist_cnt_q != 2'd2) begin
        hist_cnt_q <= hist_cnt_q + 2'd1;
      end
      if (cycles_q != 16'hFFFF) begin
        cycles_q <= cycles_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl
// Self-checking bench for cpu_run_ctrl. A tiny core model (PC with a
// counted loop 4..12 and an idle self-loop at 30) closes the loop through
// the DUT's cpu_en/cpu_reset. A behavioural reference model tracks the
// expected sequencer outputs every cycle; literal expectations pin key
// scenarios.
module tb_cpu_run_ctrl;

  localparam int HOLD_CYCLES  = 2;
  localparam bit START_HALTED = 1'b0;

  localparam int M_HOLD = 0;
  localparam int M_HALT = 1;
  localparam int M_RUN  = 2;
  localparam int M_STEP = 3;
  localparam int M_DONE = 4;

  localparam int LOOP_TOP    = 4;
  localparam int LOOP_END    = 12;
  localparam int LOOP_PASSES = 2;
  localparam int IDLE_PC     = 30;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] instr_addr = 16'd0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'd0;
  logic        ld_en = 1'b0;
  logic        cpu_en;
  logic        cpu_reset;
  logic [2:0]  state;
  logic        bp_hit;
  logic [15:0] cycles;

  int n_checks = 0;
  int n_fail   = 0;

  int core_pc   = 0;
  int core_pass = 0;

  int m_mode;
  int m_hold_left;
  bit m_resume;
  bit m_bp_hit;
  int m_exec;
  int m_hist[$];

  bit e_ready, e_en, e_rst, e_acc, e_bp, e_lp;

  bit count_ready = 1'b0;
  int ready_low   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .START_HALTED(START_HALTED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_addr(instr_addr),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .ld_en     (ld_en),
    .cpu_en    (cpu_en),
    .cpu_reset (cpu_reset),
    .state     (state),
    .bp_hit    (bp_hit),
    .cycles    (cycles)
  );

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode      = M_HOLD;
    m_hold_left = HOLD_CYCLES;
    m_resume    = 1'b0;
    m_bp_hit    = 1'b0;
    m_exec      = 0;
    m_hist.delete();
  endtask

  // Expected combinational outputs from the current model state and inputs.
  task automatic model_eval();
    e_ready = reset && (m_mode == M_HALT || m_mode == M_RUN || m_mode == M_DONE);
    e_rst   = (m_mode == M_HOLD);
    e_acc   = cmd_valid && e_ready;
    e_bp    = bp_en && (instr_addr == bp_addr) && !m_resume;
    e_lp    = ld_en && (m_hist.size() == 2) && (m_hist[0] == int'(instr_addr));
    if (m_mode == M_RUN)
      e_en = !((e_acc && cmd_op == 2'd3) || e_bp || e_lp);
    else
      e_en = (m_mode == M_STEP);
  endtask

  // Advance the model across one rising edge.
  task automatic model_edge();
    int nxt;
    bit to_hold;
    nxt     = m_mode;
    to_hold = 1'b0;
    if (e_en) begin
      m_exec++;
      m_hist.push_back(int'(instr_addr));
      if (m_hist.size() > 2) void'(m_hist.pop_front());
    end
    if (e_acc && cmd_op != 2'd1) m_bp_hit = 1'b0;
    case (m_mode)
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) nxt = START_HALTED ? M_HALT : M_RUN;
      end
      M_HALT: begin
        if (e_acc) begin
          if (cmd_op == 2'd0) begin
            nxt = M_RUN;
            m_resume = 1'b1;
          end else if (cmd_op == 2'd2) nxt = M_STEP;
          else if (cmd_op == 2'd3) to_hold = 1'b1;
        end
      end
      M_RUN: begin
        m_resume = 1'b0;
        if (e_acc && cmd_op == 2'd3) to_hold = 1'b1;
        else if (e_bp) begin
          m_bp_hit = 1'b1;
          nxt = M_HALT;
        end else if (e_lp) nxt = M_DONE;
        else if (e_acc && (cmd_op == 2'd1 || cmd_op == 2'd2)) nxt = M_HALT;
      end
      M_STEP: nxt = M_HALT;
      M_DONE: if (e_acc && cmd_op == 2'd3) to_hold = 1'b1;
      default: to_hold = 1'b1;
    endcase
    if (to_hold) model_reset();
    else m_mode = nxt;
  endtask

  task automatic compare_all();
    check_output("state", state, m_mode);
    check_output("cpu_en", cpu_en, e_en);
    check_output("cpu_reset", cpu_reset, e_rst);
    check_output("cmd_ready", cmd_ready, e_ready);
    check_output("bp_hit", bp_hit, m_bp_hit);
    check_output("cycles", cycles, (m_exec > 65535) ? 65535 : m_exec);
  endtask

  // One clock cycle: compare mid-cycle, then let the model and core step.
  task automatic tick();
    logic dut_en, dut_rst;
    #1;
    model_eval();
    compare_all();
    if (count_ready && !cmd_ready) ready_low++;
    dut_en  = cpu_en;
    dut_rst = cpu_reset;
    @(posedge clk);
    if (reset) model_edge();
    if (dut_rst) begin
      core_pc   = 0;
      core_pass = 0;
    end else if (dut_en) begin
      if (core_pc == LOOP_END && core_pass < LOOP_PASSES) begin
        core_pc = LOOP_TOP;
        core_pass++;
      end else if (core_pc != IDLE_PC) begin
        core_pc++;
      end
    end
    @(negedge clk);
    if (e_acc) cmd_valid = 1'b0;
    instr_addr = 16'(core_pc);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_output("rst_state", state, 0);
    check_output("rst_cpu_en", cpu_en, 0);
    check_output("rst_cpu_reset", cpu_reset, 1);
    check_output("rst_cmd_ready", cmd_ready, 0);
    check_output("rst_bp_hit", bp_hit, 0);
    check_output("rst_cycles", cycles, 0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic issue(input logic [1:0] op);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (cmd_valid && n < 50) begin
      tick();
      n++;
    end
    check_output("cmd_accept_timeout", n < 50, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_state(input int s, input int max_ticks, input string name);
    int n;
    n = 0;
    while (int'(state) != s && n < max_ticks) begin
      tick();
      n++;
    end
    check_output(name, state, s);
  endtask

  task automatic apply_stimulus();
    int r;
    if (!cmd_valid && $urandom_range(0, 3) == 0) begin
      r = $urandom_range(0, 15);
      cmd_op    = (r < 7) ? 2'd0 : (r < 10) ? 2'd1 : (r < 14) ? 2'd2 : 2'd3;
      cmd_valid = 1'b1;
    end
    if ($urandom_range(0, 49) == 0) begin
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = 16'($urandom_range(0, 31));
      ld_en   = 1'($urandom_range(0, 1));
    end
    if ($urandom_range(0, 399) == 0) do_reset();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    ld_en = 1'b1;
    @(negedge clk);
    do_reset();

    // Auto-run out of HOLD: cpu_reset for exactly two edges.
    tick();
    #1;
    check_output("hold1_state", state, 0);
    check_output("hold1_cpu_reset", cpu_reset, 1);
    tick();
    #1;
    check_output("run_state", state, 2);
    check_output("run_cpu_en", cpu_en, 1);
    check_output("run_cpu_reset", cpu_reset, 0);

    // Run to the idle loop and stop.
    run_until_state(4, 200, "loop_done");
    #1;
    check_output("done_addr", instr_addr, IDLE_PC);
    check_output("done_cycles", cycles, 50);
    check_output("done_cpu_en", cpu_en, 0);
    repeat (100) tick();
    #1;
    check_output("done_frozen", cycles, 50);
    check_output("done_state", state, 4);

    // Restart, run a little, then reset mid-run.
    ld_en = 1'b0;
    issue(2'd3);
    repeat (8) tick();
    #1;
    check_output("midrun_state", state, 2);
    bp_en   = 1'b1;
    bp_addr = 16'd11;
    do_reset();

    // Breakpoint at 11, resume, re-fire on the next loop pass.
    run_until_state(1, 100, "bp_halt");
    #1;
    check_output("bp_addr_hit", instr_addr, 11);
    check_output("bp_hit_set", bp_hit, 1);
    check_output("bp_cpu_en", cpu_en, 0);
    check_output("bp_cycles", cycles, 11);
    issue(2'd0);
    #1;
    check_output("resume_bp_hit", bp_hit, 0);
    check_output("resume_state", state, 2);
    check_output("resume_cpu_en", cpu_en, 1);
    run_until_state(1, 100, "bp_refire");
    #1;
    check_output("refire_addr", instr_addr, 11);
    check_output("refire_cycles", cycles, 20);

    // Park at address 0 with a breakpoint there, then single-step.
    bp_addr = 16'd0;
    issue(2'd3);
    run_until_state(1, 20, "bp0_halt");
    #1;
    check_output("bp0_addr", instr_addr, 0);
    check_output("bp0_cycles", cycles, 0);
    bp_addr     = 16'd1;
    ready_low   = 0;
    count_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(2'd2);
      tick();
    end
    tick();
    tick();
    count_ready = 1'b0;
    #1;
    check_output("step_ready_low", ready_low, 3);
    check_output("step_addr", instr_addr, 3);
    check_output("step_cycles", cycles, 3);
    check_output("step_state", state, 1);

    // RESTART in the same cycle a breakpoint would fire.
    bp_en = 1'b0;
    issue(2'd0);
    repeat (4) tick();
    bp_en     = 1'b1;
    bp_addr   = instr_addr;
    cmd_valid = 1'b1;
    cmd_op    = 2'd3;
    #1;
    check_output("coinc_cpu_en", cpu_en, 0);
    check_output("coinc_state_before", state, 2);
    tick();
    #1;
    check_output("coinc_state", state, 0);
    check_output("coinc_bp_hit", bp_hit, 0);
    check_output("coinc_cycles", cycles, 0);
    bp_en = 1'b0;
    tick();
    tick();
    #1;
    check_output("coinc_resume_state", state, 2);
    check_output("coinc_resume_addr", instr_addr, 0);

    // Randomized traffic against the reference model.
    repeat (3000) begin
      apply_stimulus();
      tick();
    end

    // Counter saturation.
    cmd_valid = 1'b0;
    bp_en     = 1'b0;
    ld_en     = 1'b0;
    do_reset();
    repeat (70000) tick();
    #1;
    check_output("sat_cycles", cycles, 16'hFFFF);
    check_output("sat_state", state, 2);
    repeat (10) tick();
    #1;
    check_output("sat_hold", cycles, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
